// File: rtl/bus_master_port.sv
// Bus master port: arbitrates for the bus, serializes address/write data MSB first,
// waits (with timeout) for the slave response and assembles serial read data.
module bus_master_port #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  read_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    output logic                  request,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  err,
    output logic                  bus_req,
    input  logic                  bus_grant,
    output logic                  m_valid,
    output logic                  m_mode,
    output logic                  m_addr,
    output logic                  m_wdata,
    input  logic                  s_ready,
    input  logic                  s_rdata
);

    localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW   = $clog2(MAXW + 1);
    localparam int TW   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, REQ, ADDR, WDATA, WACK, RWAIT, RDATA, DONE
    } state_t;

    state_t                state_q;
    logic [CW-1:0]         bit_cnt_q;
    logic [TW-1:0]         wait_cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q, addr_sh_q;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_sh_q, data_out_q;
    logic [DATA_WIDTH-2:0] rdata_sh_q;
    logic                  rd_q, err_q, dvalid_q;
    logic [DATA_WIDTH-1:0] rdata_next;

    assign rdata_next = {rdata_sh_q, s_rdata};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            wait_cnt_q <= '0;
            addr_q     <= '0;
            addr_sh_q  <= '0;
            wdata_q    <= '0;
            wdata_sh_q <= '0;
            rdata_sh_q <= '0;
            data_out_q <= '0;
            rd_q       <= 1'b0;
            err_q      <= 1'b0;
            dvalid_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (enable) begin
                    addr_q  <= addr_in;
                    wdata_q <= data_in;
                    rd_q    <= read_en;
                    state_q <= REQ;
                end
                // Every (re)start reloads the shifters so an abort resends from the MSB.
                REQ: if (bus_grant) begin
                    addr_sh_q  <= addr_q;
                    wdata_sh_q <= wdata_q;
                    bit_cnt_q  <= '0;
                    state_q    <= ADDR;
                end
                ADDR: begin
                    if (!bus_grant) begin
                        state_q <= REQ;
                    end else if (bit_cnt_q == CW'(ADDR_WIDTH - 1)) begin
                        bit_cnt_q  <= '0;
                        wait_cnt_q <= '0;
                        state_q    <= rd_q ? RWAIT : WDATA;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CW'(1);
                        addr_sh_q <= addr_sh_q << 1;
                    end
                end
                WDATA: begin
                    if (!bus_grant) begin
                        state_q <= REQ;
                    end else if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
                        bit_cnt_q  <= '0;
                        wait_cnt_q <= '0;
                        state_q    <= WACK;
                    end else begin
                        bit_cnt_q  <= bit_cnt_q + CW'(1);
                        wdata_sh_q <= wdata_sh_q << 1;
                    end
                end
                WACK, RWAIT: begin
                    if (s_ready) begin
                        bit_cnt_q <= '0;
                        state_q   <= (state_q == WACK) ? DONE : RDATA;
                    end else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + TW'(1);
                    end
                end
                RDATA: begin
                    if (!bus_grant) begin
                        state_q <= REQ;
                    end else begin
                        rdata_sh_q <= rdata_next[DATA_WIDTH-2:0];
                        if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
                            data_out_q <= rdata_next;
                            dvalid_q   <= 1'b1;
                            state_q    <= DONE;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CW'(1);
                        end
                    end
                end
                DONE: begin
                    err_q    <= 1'b0;
                    dvalid_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign request    = (state_q != IDLE);
    assign bus_req    = (state_q != IDLE) && (state_q != DONE);
    assign m_valid    = (state_q == ADDR) || (state_q == WDATA);
    assign m_mode     = m_valid && !rd_q;
    assign m_addr     = (state_q == ADDR) && addr_sh_q[ADDR_WIDTH-1];
    assign m_wdata    = (state_q == WDATA) && wdata_sh_q[DATA_WIDTH-1];
    assign data_out   = data_out_q;
    assign data_valid = dvalid_q;
    assign err        = err_q;

endmodule

// File: doc/bus_master_port.md
BUS_MASTER_PORT -- requirements
Module: bus_master_port

Interface
REQ-001 Parameter ADDR_WIDTH SHALL default to 14 and set the transfer address width.
REQ-002 Parameter DATA_WIDTH SHALL default to 8 and set the transfer data width.
REQ-003 Parameter TIMEOUT SHALL default to 16 and set the maximum number of cycles spent waiting for a slave response.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  transfer start strobe from the controller.
REQ-007 read_en  input  1  1 = read, 0 = write; sampled with enable.
REQ-008 data_in  input  DATA_WIDTH  write data; sampled with enable.
REQ-009 addr_in  input  ADDR_WIDTH  target address; sampled with enable.
REQ-010 request  output  1  port busy; controller returns to idle only when this is 0.
REQ-011 data_out  output  DATA_WIDTH  last read data.
REQ-012 data_valid  output  1  one-cycle pulse when data_out is updated by a successful read.
REQ-013 err  output  1  one-cycle pulse when a transfer ends by timeout.
REQ-014 bus_req  output  1  bus request to the arbiter.
REQ-015 bus_grant  input  1  arbiter grant.
REQ-016 m_valid  output  1  serial bus lines carry valid bits this cycle.
REQ-017 m_mode  output  1  1 = write, 0 = read; valid while m_valid is 1.
REQ-018 m_addr  output  1  serial address bit, MSB first.
REQ-019 m_wdata  output  1  serial write-data bit, MSB first.
REQ-020 s_ready  input  1  slave response: write acknowledged, or read data follows.
REQ-021 s_rdata  input  1  serial read-data bit from the slave, MSB first.

Function
REQ-022 The FSM SHALL have these states: IDLE, REQ, ADDR, WDATA, WACK, RWAIT, RDATA, DONE.
REQ-023 Outputs SHALL be decoded from the registered state: request = 1 in every state except IDLE; bus_req = 1 in REQ through RDATA.
REQ-024 IDLE: if enable = 1 at an edge, the block SHALL latch addr_in, data_in and read_en and enter REQ.
REQ-025 enable SHALL be ignored in every state other than IDLE.
REQ-026 REQ: bus_grant = 1 at an edge SHALL move the FSM to ADDR; otherwise it SHALL remain in REQ indefinitely.
REQ-027 ADDR SHALL last exactly ADDR_WIDTH cycles with m_valid = 1, presenting address bits MSB to LSB on m_addr, one per cycle.
REQ-028 After ADDR, a write SHALL go to WDATA and a read SHALL go to RWAIT.
REQ-029 WDATA SHALL last exactly DATA_WIDTH cycles with m_valid = 1, presenting data bits MSB first on m_wdata; it SHALL then go to WACK.
REQ-030 WACK and RWAIT: s_ready = 1 at an edge SHALL advance the FSM (WACK to DONE, RWAIT to RDATA).
REQ-031 In WACK and RWAIT, a wait counter SHALL count cycles; if TIMEOUT cycles elapse without s_ready, the FSM SHALL go to DONE with err = 1.
REQ-032 RDATA SHALL last DATA_WIDTH cycles, shifting in s_rdata each cycle (first sample is the MSB).
REQ-033 DONE SHALL last one cycle; for a successful read, data_out SHALL show the assembled byte and data_valid SHALL be 1; the FSM SHALL then go to IDLE.
REQ-034 m_valid, m_addr and m_wdata SHALL be 0 outside ADDR and WDATA; m_mode SHALL be 0 when m_valid = 0.
REQ-035 If bus_grant falls during ADDR, WDATA or RDATA, the block SHALL abort, return to REQ and restart the whole transfer from the address MSB; it SHALL NOT pulse err.
REQ-036 data_out SHALL hold its value until the next successful read.
REQ-037 Bit counters SHALL be sized from ADDR_WIDTH and DATA_WIDTH; the wait counter SHALL hold TIMEOUT without wrap-around.

Reset
REQ-038 reset = 0 SHALL immediately force IDLE and zero request, data_out, data_valid, err, bus_req, m_valid, m_mode, m_addr, m_wdata and all counters and latched fields, including mid-transfer.
REQ-039 After reset is released, the first enable SHALL start a transfer normally.

Verification
REQ-040 Write: enable at cycle n with addr 1001 and data 212, grant held high, s_ready at n+24 -> REQ at n+1; m_addr serializes 00001111101001 on n+2..n+15; m_wdata serializes 11010100 on n+16..n+23; DONE at n+25; request = 0 from n+26.
REQ-041 Read: enable at n with addr 5012 and read_en = 1, s_ready at n+16, s_rdata = 01100101 on n+17..n+24 -> data_out = 101 and data_valid = 1 at n+25.
REQ-042 Grant delay and drop: grant delayed 5 cycles -> ADDR starts 1 cycle after grant; grant dropped mid-ADDR and reasserted -> full address is re-sent and err stays 0.
REQ-043 Timeout: read with s_ready never asserted -> DONE at n+32, err = 1, data_valid = 0, data_out unchanged.
REQ-044 Busy enable and reset: enable pulsed during WDATA -> no effect; reset asserted in RDATA -> all outputs 0 immediately, and a new write then completes per REQ-040.
